mem_port_arbiter: RTL and testbench

//   Shares the single main_memory access port between instruction fetch (128-bit bundle reads)
//   and the LSU (sized loads/stores). Sits between instruction_fetch/lsu and main_memory;

---
 rtl/mem_port_arbiter.sv | 119 +++++++++++
 tb/tb_mem_port_arbiter.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Arbitrates the single main_memory port between instruction fetch and the LSU,
// sequencing MEM_LAT-cycle accesses and bounding fetch starvation.
module mem_port_arbiter #(
  parameter int MEM_LAT    = 1,
  parameter int STARVE_MAX = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         if_req,
  input  logic [31:0]  if_addr,
  input  logic         if_flush,
  output logic         if_gnt,
  output logic         if_rvalid,
  output logic [127:0] if_rdata,
  input  logic         lsu_req,
  input  logic         lsu_we,
  input  logic [31:0]  lsu_addr,
  input  logic [31:0]  lsu_wdata,
  input  logic [1:0]   lsu_size,
  input  logic         lsu_zero_ext,
  output logic         lsu_gnt,
  output logic         lsu_rvalid,
  output logic [31:0]  lsu_rdata,
  output logic         mem_en,
  output logic         mem_we,
  output logic [31:0]  mem_addr,
  output logic [31:0]  mem_wdata,
  output logic [1:0]   mem_size,
  output logic         mem_zero_ext,
  input  logic [127:0] mem_bundle,
  input  logic [31:0]  mem_rdata,
  output logic         stall_out
);

  localparam int CW = $clog2(MEM_LAT + 1);
  localparam int SW = $clog2(STARVE_MAX + 1);

  typedef enum logic {IDLE, WAIT} state_t;

  state_t          state;
  logic [CW-1:0]   cnt;
  logic [SW-1:0]   starve_cnt;
  logic            own_fetch, own_store, own_flush;
  logic            arb_ok, starve_hit, grant;
  logic            cap, cap_fetch, cap_store, cap_flush;

  // WAIT with cnt==0 is the completion cycle, where a new grant may overlap the rvalid
  assign arb_ok     = rst & ((state == IDLE) | (cnt == '0));
  assign starve_hit = (starve_cnt == SW'(STARVE_MAX));
  assign if_gnt     = arb_ok & if_req & (~lsu_req | starve_hit);
  assign lsu_gnt    = arb_ok & lsu_req & ~if_gnt;
  assign grant      = if_gnt | lsu_gnt;
  assign stall_out  = rst & ((if_req & ~if_gnt) | (lsu_req & ~lsu_gnt));

  assign mem_en       = grant;
  assign mem_we       = lsu_gnt & lsu_we;
  assign mem_addr     = lsu_gnt ? lsu_addr : (if_gnt ? if_addr : 32'h0);
  assign mem_wdata    = lsu_gnt ? lsu_wdata : 32'h0;
  assign mem_size     = lsu_gnt ? lsu_size : 2'b00;
  assign mem_zero_ext = lsu_gnt & lsu_zero_ext;

  // Capture happens in the cycle memory data is valid: the grant cycle itself when MEM_LAT==1
  always_comb begin
    cap       = 1'b0;
    cap_fetch = 1'b0;
    cap_store = 1'b0;
    cap_flush = 1'b0;
    if (MEM_LAT == 1) begin
      cap       = grant;
      cap_fetch = if_gnt;
      cap_store = lsu_gnt & lsu_we;
      cap_flush = if_flush;
    end else begin
      cap       = (state == WAIT) && (cnt == CW'(1));
      cap_fetch = own_fetch;
      cap_store = own_store;
      cap_flush = own_flush | if_flush;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      cnt        <= '0;
      starve_cnt <= '0;
      own_fetch  <= 1'b0;
      own_store  <= 1'b0;
      own_flush  <= 1'b0;
      if_rvalid  <= 1'b0;
      if_rdata   <= '0;
      lsu_rvalid <= 1'b0;
      lsu_rdata  <= '0;
    end else begin
      if_rvalid  <= cap & cap_fetch & ~cap_flush;
      lsu_rvalid <= cap & ~cap_fetch;
      if (cap & cap_fetch & ~cap_flush) if_rdata <= mem_bundle;
      if (cap & ~cap_fetch & ~cap_store) lsu_rdata <= mem_rdata;

      if (if_req & ~if_gnt) begin
        if (!starve_hit) starve_cnt <= starve_cnt + SW'(1);
      end else begin
        starve_cnt <= '0;
      end

      own_flush <= grant ? if_flush : (own_flush | if_flush);

      if (grant && (MEM_LAT > 1)) begin
        state     <= WAIT;
        cnt       <= CW'(MEM_LAT - 1);
        own_fetch <= if_gnt;
        own_store <= lsu_gnt & lsu_we;
      end else if (state == WAIT) begin
        if (cnt == '0) state <= IDLE;
        else           cnt   <= cnt - CW'(1);
      end
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: three instances (MEM_LAT 1,2,3) share stimulus,
// each scenario checks the instance whose latency it targets.
module tb_mem_port_arbiter;

  logic         clk = 1'b0;
  logic         rst;
  logic         if_req, if_flush, lsu_req, lsu_we, lsu_zero_ext;
  logic [31:0]  if_addr, lsu_addr, lsu_wdata, mem_rdata;
  logic [1:0]   lsu_size;
  logic [127:0] mem_bundle;

  logic [3:1]   if_gnt, if_rvalid, lsu_gnt, lsu_rvalid, mem_en, mem_we, mem_zero_ext, stall_out;
  logic [127:0] if_rdata  [1:3];
  logic [31:0]  lsu_rdata [1:3];
  logic [31:0]  mem_addr  [1:3];
  logic [31:0]  mem_wdata [1:3];
  logic [1:0]   mem_size  [1:3];

  int checks = 0;
  int errors = 0;

  localparam logic [127:0] B1 = 128'h11112222_33334444_55556666_77778888;
  localparam logic [127:0] B2 = 128'hA5A5A5A5_0F0F0F0F_C3C3C3C3_12345678;
  localparam logic [127:0] B3 = 128'hFFFF0000_EEEE1111_DDDD2222_CCCC3333;
  localparam logic [127:0] BX = 128'hBAD0BAD0_BAD0BAD0_BAD0BAD0_BAD0BAD0;

  always #5 clk = ~clk;

  for (genvar g = 1; g <= 3; g++) begin : g_dut
    mem_port_arbiter #(.MEM_LAT(g), .STARVE_MAX(4)) dut (
      .clk(clk), .rst(rst),
      .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
      .if_gnt(if_gnt[g]), .if_rvalid(if_rvalid[g]), .if_rdata(if_rdata[g]),
      .lsu_req(lsu_req), .lsu_we(lsu_we), .lsu_addr(lsu_addr), .lsu_wdata(lsu_wdata),
      .lsu_size(lsu_size), .lsu_zero_ext(lsu_zero_ext),
      .lsu_gnt(lsu_gnt[g]), .lsu_rvalid(lsu_rvalid[g]), .lsu_rdata(lsu_rdata[g]),
      .mem_en(mem_en[g]), .mem_we(mem_we[g]), .mem_addr(mem_addr[g]),
      .mem_wdata(mem_wdata[g]), .mem_size(mem_size[g]), .mem_zero_ext(mem_zero_ext[g]),
      .mem_bundle(mem_bundle), .mem_rdata(mem_rdata), .stall_out(stall_out[g])
    );
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    if_req = 0; if_addr = 0; if_flush = 0;
    lsu_req = 0; lsu_we = 0; lsu_addr = 0; lsu_wdata = 0; lsu_size = 0; lsu_zero_ext = 0;
    mem_bundle = BX; mem_rdata = 32'hBAD0BAD0;
  endtask

  task automatic do_reset();
    rst = 0;
    idle_inputs();
    cyc();
    cyc();
    rst = 1;
  endtask

  initial begin
    rst = 0;
    idle_inputs();
    #2;
    for (int g = 1; g <= 3; g++) begin
      chk("rst_mem_en", mem_en[g], 0);
      chk("rst_if_rvalid", if_rvalid[g], 0);
      chk("rst_lsu_rvalid", lsu_rvalid[g], 0);
      chk("rst_if_rdata", if_rdata[g], 0);
      chk("rst_lsu_rdata", lsu_rdata[g], 0);
    end
    cyc();
    rst = 1;

    // Single fetch, MEM_LAT=2
    if_req = 1; if_addr = 32'h10;
    @(negedge clk);
    chk("t2_if_gnt", if_gnt[2], 1);
    chk("t2_mem_en", mem_en[2], 1);
    chk("t2_mem_addr", mem_addr[2], 32'h10);
    chk("t2_mem_we", mem_we[2], 0);
    chk("t2_stall_c0", stall_out[2], 0);
    cyc();
    if_req = 0; mem_bundle = B1;
    @(negedge clk);
    chk("t2_mem_en_c1", mem_en[2], 0);
    chk("t2_rvalid_c1", if_rvalid[2], 0);
    chk("t2_stall_c1", stall_out[2], 0);
    cyc();
    mem_bundle = BX;
    @(negedge clk);
    chk("t2_rvalid_c2", if_rvalid[2], 1);
    chk("t2_rdata_c2", if_rdata[2], B1);
    cyc();
    @(negedge clk);
    chk("t2_rvalid_c3", if_rvalid[2], 0);
    chk("t2_rdata_hold", if_rdata[2], B1);
    cyc();

    // Fetch and load collide, MEM_LAT=2
    if_req = 1; if_addr = 32'h40;
    lsu_req = 1; lsu_we = 0; lsu_addr = 32'h100; lsu_size = 2;
    @(negedge clk);
    chk("t3_lsu_gnt_c0", lsu_gnt[2], 1);
    chk("t3_if_gnt_c0", if_gnt[2], 0);
    chk("t3_addr_c0", mem_addr[2], 32'h100);
    chk("t3_stall_c0", stall_out[2], 1);
    cyc();
    lsu_req = 0; mem_rdata = 32'hCAFE0001;
    @(negedge clk);
    chk("t3_if_gnt_c1", if_gnt[2], 0);
    chk("t3_mem_en_c1", mem_en[2], 0);
    chk("t3_stall_c1", stall_out[2], 1);
    cyc();
    mem_rdata = 32'hBAD0BAD0;
    @(negedge clk);
    chk("t3_if_gnt_c2", if_gnt[2], 1);
    chk("t3_addr_c2", mem_addr[2], 32'h40);
    chk("t3_lsu_rvalid_c2", lsu_rvalid[2], 1);
    chk("t3_lsu_rdata_c2", lsu_rdata[2], 32'hCAFE0001);
    chk("t3_stall_c2", stall_out[2], 0);
    cyc();
    if_req = 0; mem_bundle = B2;
    @(negedge clk);
    chk("t3_if_rvalid_c3", if_rvalid[2], 0);
    cyc();
    mem_bundle = BX;
    @(negedge clk);
    chk("t3_if_rvalid_c4", if_rvalid[2], 1);
    chk("t3_if_rdata_c4", if_rdata[2], B2);
    cyc();
    cyc();

    // Flush of an outstanding fetch, MEM_LAT=2
    if_req = 1; if_addr = 32'h20;
    @(negedge clk);
    chk("t5_if_gnt_c0", if_gnt[2], 1);
    cyc();
    if_req = 0; if_flush = 1; mem_bundle = B3;
    lsu_req = 1; lsu_we = 0; lsu_addr = 32'h300;
    @(negedge clk);
    chk("t5_lsu_gnt_c1", lsu_gnt[2], 0);
    chk("t5_stall_c1", stall_out[2], 1);
    cyc();
    if_flush = 0; mem_bundle = BX;
    @(negedge clk);
    chk("t5_if_rvalid_c2", if_rvalid[2], 0);
    chk("t5_if_rdata_c2", if_rdata[2], B2);
    chk("t5_lsu_gnt_c2", lsu_gnt[2], 1);
    chk("t5_addr_c2", mem_addr[2], 32'h300);
    cyc();
    lsu_req = 0; mem_rdata = 32'h13579BDF;
    @(negedge clk);
    chk("t5_if_rvalid_c3", if_rvalid[2], 0);
    cyc();
    mem_rdata = 32'hBAD0BAD0;
    @(negedge clk);
    chk("t5_lsu_rvalid_c4", lsu_rvalid[2], 1);
    chk("t5_lsu_rdata_c4", lsu_rdata[2], 32'h13579BDF);
    cyc();

    // Store, MEM_LAT=2
    lsu_req = 1; lsu_we = 1; lsu_addr = 32'h200; lsu_wdata = 32'hDEADBEEF; lsu_size = 2;
    @(negedge clk);
    chk("t6_lsu_gnt_c0", lsu_gnt[2], 1);
    chk("t6_mem_we_c0", mem_we[2], 1);
    chk("t6_wdata_c0", mem_wdata[2], 32'hDEADBEEF);
    chk("t6_size_c0", mem_size[2], 2);
    chk("t6_addr_c0", mem_addr[2], 32'h200);
    cyc();
    lsu_req = 0; lsu_we = 0; mem_rdata = 32'h55555555;
    @(negedge clk);
    chk("t6_mem_we_c1", mem_we[2], 0);
    chk("t6_lsu_rvalid_c1", lsu_rvalid[2], 0);
    cyc();
    mem_rdata = 32'hBAD0BAD0;
    @(negedge clk);
    chk("t6_lsu_rvalid_c2", lsu_rvalid[2], 1);
    chk("t6_lsu_rdata_c2", lsu_rdata[2], 32'h13579BDF);
    cyc();
    @(negedge clk);
    chk("t6_lsu_rvalid_c3", lsu_rvalid[2], 0);
    cyc();

    // Starvation bound, MEM_LAT=1
    do_reset();
    lsu_req = 1; lsu_addr = 32'h600; if_req = 1; if_addr = 32'h700;
    for (int c = 0; c < 7; c++) begin
      @(negedge clk);
      chk($sformatf("t4_lsu_gnt_c%0d", c), lsu_gnt[1], (c != 4));
      chk($sformatf("t4_if_gnt_c%0d", c), if_gnt[1], (c == 4));
      cyc();
    end
    idle_inputs();

    // Reset during WAIT, MEM_LAT=3
    do_reset();
    lsu_req = 1; lsu_addr = 32'h400; mem_rdata = 32'h77777777;
    @(negedge clk);
    chk("t1_lsu_gnt_c0", lsu_gnt[3], 1);
    cyc();
    lsu_req = 0;
    rst = 0;
    #2;
    chk("t1_rst_mem_en", mem_en[3], 0);
    chk("t1_rst_stall", stall_out[3], 0);
    chk("t1_rst_lsu_rvalid", lsu_rvalid[3], 0);
    rst = 1;
    cyc();
    lsu_req = 1; lsu_addr = 32'h500;
    @(negedge clk);
    chk("t1_regrant_c2", lsu_gnt[3], 1);
    chk("t1_lsu_rvalid_c2", lsu_rvalid[3], 0);
    cyc();
    lsu_req = 0;
    @(negedge clk);
    chk("t1_lsu_rvalid_c3", lsu_rvalid[3], 0);
    chk("t1_lsu_rdata_c3", lsu_rdata[3], 0);
    cyc();
    mem_rdata = 32'h0BADF00D;
    @(negedge clk);
    chk("t1_lsu_rvalid_c4", lsu_rvalid[3], 0);
    cyc();
    mem_rdata = 32'hBAD0BAD0;
    @(negedge clk);
    chk("t1_lsu_rvalid_c5", lsu_rvalid[3], 1);
    chk("t1_lsu_rdata_c5", lsu_rdata[3], 32'h0BADF00D);
    cyc();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
